// File: rtl/riscv_mem_arbiter.sv
// rtl/riscv_mem_arbiter.sv - fetch/data arbiter onto one memory port, one transaction in flight.
// Optional MEM_ARB_TIMEOUT_EN: error-completes a transaction stuck TIMEOUT cycles in REQ/WAIT.
module riscv_mem_arbiter #(
  parameter int XLEN       = 32,
  parameter int MAX_STREAK = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [XLEN-1:0]   if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [XLEN-1:0]   if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [XLEN-1:0]   d_addr,
  input  logic [XLEN-1:0]   d_wdata,
  input  logic [XLEN/8-1:0] d_be,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [XLEN-1:0]   d_rdata,
  output logic              d_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_be,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_err,
  output logic              busy,
  output logic              proto_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  localparam int SW = $clog2(MAX_STREAK + 1);

  state_t          state;
  logic            owner_d;
  logic [SW-1:0]   streak;
  logic [XLEN-1:0] if_rdata_q, d_rdata_q;
  logic            if_err_q, d_err_q;

  logic            data_win, grant_d, grant_f;
  logic            tmo_hit, rsp_fire, rsp_err;
  logic [XLEN-1:0] rsp_rdata;

  // Data wins unless fetch is waiting and has already lost MAX_STREAK times in a row
  always_comb begin
    data_win = d_req && !(if_req && (streak == SW'(MAX_STREAK)));
    grant_d  = rst_n && (state == IDLE) && data_win;
    grant_f  = rst_n && (state == IDLE) && if_req && !data_win;
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= '0;
    end else if (state == IDLE) begin
      tcnt <= '0;
    end else if (tcnt != TW'(TIMEOUT)) begin
      tcnt <= tcnt + 1'b1;
    end
  end

  // A genuine response in the expiry cycle takes precedence over the timeout
  assign tmo_hit = (state != IDLE) && (tcnt == TW'(TIMEOUT)) &&
                   !((state == WAIT) && mem_rvalid);
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign tmo_hit        = 1'b0;
`endif

  always_comb begin
    rsp_fire  = ((state == WAIT) && mem_rvalid) || tmo_hit;
    rsp_rdata = tmo_hit ? '0 : mem_rdata;
    rsp_err   = tmo_hit ? 1'b1 : mem_err;
  end

  assign if_gnt    = grant_f;
  assign d_gnt     = grant_d;
  assign if_rvalid = rsp_fire && !owner_d;
  assign d_rvalid  = rsp_fire && owner_d;
  assign if_rdata  = if_rvalid ? rsp_rdata : if_rdata_q;
  assign if_err    = if_rvalid ? rsp_err   : if_err_q;
  assign d_rdata   = d_rvalid  ? rsp_rdata : d_rdata_q;
  assign d_err     = d_rvalid  ? rsp_err   : d_err_q;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner_d    <= 1'b0;
      streak     <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      proto_err  <= 1'b0;
      if_rdata_q <= '0;
      if_err_q   <= 1'b0;
      d_rdata_q  <= '0;
      d_err_q    <= 1'b0;
    end else begin
      if (mem_rvalid && (state != WAIT)) begin
        proto_err <= 1'b1;
      end
      if (if_rvalid) begin
        if_rdata_q <= rsp_rdata;
        if_err_q   <= rsp_err;
      end
      if (d_rvalid) begin
        d_rdata_q <= rsp_rdata;
        d_err_q   <= rsp_err;
      end

      case (state)
        IDLE: begin
          if (grant_d) begin
            state     <= REQ;
            owner_d   <= 1'b1;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_be    <= d_be;
            if (!if_req) begin
              streak <= '0;
            end else if (streak != SW'(MAX_STREAK)) begin
              streak <= streak + 1'b1;
            end
          end else if (grant_f) begin
            state     <= REQ;
            owner_d   <= 1'b0;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_be    <= '1;
            streak    <= '0;
          end
        end
        REQ: begin
          if (tmo_hit) begin
            state   <= IDLE;
            mem_req <= 1'b0;
          end else if (mem_gnt) begin
            state   <= WAIT;
            mem_req <= 1'b0;
          end
        end
        WAIT: begin
          if (rsp_fire) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb/tb_riscv_mem_arbiter.sv - directed self-checking bench for riscv_mem_arbiter.
module tb_riscv_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_be;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid, mem_err;
  logic [31:0] mem_rdata;
  logic        busy, proto_err;

  int pass_cnt = 0;
  int total    = 0;

  riscv_mem_arbiter #(.XLEN(32), .MAX_STREAK(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .mem_err(mem_err), .busy(busy), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  // Each cycle: inputs are driven 2 time units after the edge, outputs sampled 1 unit later
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; if_req = 1'b1; if_addr = 32'h40; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; d_be = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    mem_rdata = '0; mem_err = 1'b0;
    tick(); tick();
    #1;
    total++; if (if_gnt !== 1'b0) $display("FAIL reset_if_gnt: got %b want 0", if_gnt); else pass_cnt++;
    total++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b want 0", mem_req); else pass_cnt++;
    total++; if (mem_addr !== 32'h0) $display("FAIL reset_mem_addr: got %h want 0", mem_addr); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    total++; if (proto_err !== 1'b0) $display("FAIL reset_proto_err: got %b want 0", proto_err); else pass_cnt++;
    total++; if (if_rdata !== 32'h0) $display("FAIL reset_if_rdata: got %h want 0", if_rdata); else pass_cnt++;
    if_req = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_fetch();
    if_req = 1'b1; if_addr = 32'h100;
    #1;
    total++; if (if_gnt !== 1'b1) $display("FAIL fetch_gnt: got %b want 1", if_gnt); else pass_cnt++;
    total++; if (d_gnt !== 1'b0) $display("FAIL fetch_d_gnt: got %b want 0", d_gnt); else pass_cnt++;
    tick();
    if_req = 1'b0; mem_gnt = 1'b1;
    #1;
    total++; if (mem_req !== 1'b1) $display("FAIL fetch_mem_req: got %b want 1", mem_req); else pass_cnt++;
    total++; if (mem_addr !== 32'h100) $display("FAIL fetch_mem_addr: got %h want 100", mem_addr); else pass_cnt++;
    total++; if (mem_we !== 1'b0) $display("FAIL fetch_mem_we: got %b want 0", mem_we); else pass_cnt++;
    total++; if (mem_be !== 4'hF) $display("FAIL fetch_mem_be: got %h want f", mem_be); else pass_cnt++;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF; mem_err = 1'b0;
    #1;
    total++; if (mem_req !== 1'b0) $display("FAIL fetch_mem_req_drop: got %b want 0", mem_req); else pass_cnt++;
    total++; if (if_rvalid !== 1'b1) $display("FAIL fetch_rvalid: got %b want 1", if_rvalid); else pass_cnt++;
    total++; if (if_rdata !== 32'hDEADBEEF) $display("FAIL fetch_rdata: got %h want deadbeef", if_rdata); else pass_cnt++;
    total++; if (if_err !== 1'b0) $display("FAIL fetch_err: got %b want 0", if_err); else pass_cnt++;
    total++; if (d_rvalid !== 1'b0) $display("FAIL fetch_d_rvalid: got %b want 0", d_rvalid); else pass_cnt++;
    tick();
    mem_rvalid = 1'b0; mem_rdata = 32'h12345678;
    #1;
    total++; if (if_rvalid !== 1'b0) $display("FAIL fetch_rvalid_pulse: got %b want 0", if_rvalid); else pass_cnt++;
    total++; if (if_rdata !== 32'hDEADBEEF) $display("FAIL fetch_rdata_hold: got %h want deadbeef", if_rdata); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL fetch_idle: got %b want 0", busy); else pass_cnt++;
    tick();
  endtask

  task automatic test_simultaneous();
    if_req = 1'b1; if_addr = 32'h104;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h55; d_be = 4'hF;
    #1;
    total++; if (d_gnt !== 1'b1) $display("FAIL simul_d_gnt: got %b want 1", d_gnt); else pass_cnt++;
    total++; if (if_gnt !== 1'b0) $display("FAIL simul_if_gnt: got %b want 0", if_gnt); else pass_cnt++;
    tick();
    d_req = 1'b0; mem_gnt = 1'b1;
    #1;
    total++; if (mem_we !== 1'b1) $display("FAIL simul_mem_we: got %b want 1", mem_we); else pass_cnt++;
    total++; if (mem_wdata !== 32'h55) $display("FAIL simul_mem_wdata: got %h want 55", mem_wdata); else pass_cnt++;
    total++; if (mem_addr !== 32'h200) $display("FAIL simul_mem_addr: got %h want 200", mem_addr); else pass_cnt++;
    total++; if (if_gnt !== 1'b0) $display("FAIL simul_if_gnt_req: got %b want 0", if_gnt); else pass_cnt++;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0;
    #1;
    total++; if (d_rvalid !== 1'b1) $display("FAIL simul_d_rvalid: got %b want 1", d_rvalid); else pass_cnt++;
    total++; if (if_rvalid !== 1'b0) $display("FAIL simul_if_rvalid: got %b want 0", if_rvalid); else pass_cnt++;
    total++; if (if_gnt !== 1'b0) $display("FAIL simul_if_gnt_wait: got %b want 0", if_gnt); else pass_cnt++;
    tick();
    mem_rvalid = 1'b0;
    #1;
    total++; if (if_gnt !== 1'b1) $display("FAIL simul_fetch_after: got %b want 1", if_gnt); else pass_cnt++;
    tick();
    if_req = 1'b0; mem_gnt = 1'b1;
    #1;
    total++; if (mem_addr !== 32'h104) $display("FAIL simul_fetch_addr: got %h want 104", mem_addr); else pass_cnt++;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE0001;
    tick();
    mem_rvalid = 1'b0;
    tick();
  endtask

  task automatic test_starvation();
    logic [5:0] order;
    order = 6'b101111;
    if_req = 1'b1; if_addr = 32'h300; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
    for (int i = 0; i < 6; i++) begin
      #1;
      total++;
      if (d_gnt !== order[i] || if_gnt !== !order[i])
        $display("FAIL starve_grant%0d: got d=%b f=%b want d=%b f=%b", i, d_gnt, if_gnt, order[i], !order[i]);
      else pass_cnt++;
      tick();
      if (i == 5) begin if_req = 1'b0; d_req = 1'b0; end
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0; mem_rvalid = 1'b1;
      tick();
      mem_rvalid = 1'b0;
    end
    tick();
  endtask

  task automatic test_backpressure();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_wdata = 32'hA5A5A5A5; d_be = 4'h3;
    #1;
    total++; if (d_gnt !== 1'b1) $display("FAIL bp_gnt: got %b want 1", d_gnt); else pass_cnt++;
    tick();
    d_req = 1'b0; d_addr = 32'hFFFF0000; d_wdata = 32'h11111111; d_be = 4'hC;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h300 || mem_wdata !== 32'hA5A5A5A5 || mem_be !== 4'h3 || busy !== 1'b1)
        $display("FAIL bp_hold%0d: got req=%b addr=%h wdata=%h be=%h busy=%b want 1/300/a5a5a5a5/3/1",
                 i, mem_req, mem_addr, mem_wdata, mem_be, busy);
      else pass_cnt++;
      tick();
    end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_err = 1'b1; mem_rdata = 32'h0BAD0BAD;
    #1;
    total++; if (d_rvalid !== 1'b1 || d_err !== 1'b1) $display("FAIL bp_rsp: got rvalid=%b err=%b want 1/1", d_rvalid, d_err); else pass_cnt++;
    tick();
    mem_rvalid = 1'b0; mem_err = 1'b0;
    #1;
    total++; if (d_err !== 1'b1) $display("FAIL bp_err_hold: got %b want 1", d_err); else pass_cnt++;
    total++; if (d_rdata !== 32'h0BAD0BAD) $display("FAIL bp_rdata_hold: got %h want 0bad0bad", d_rdata); else pass_cnt++;
    tick();
  endtask

  task automatic test_stray();
    mem_rvalid = 1'b1; mem_rdata = 32'h77;
    #1;
    total++; if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0) $display("FAIL stray_rvalid: got if=%b d=%b want 0/0", if_rvalid, d_rvalid); else pass_cnt++;
    total++; if (proto_err !== 1'b0) $display("FAIL stray_pre: got %b want 0", proto_err); else pass_cnt++;
    tick();
    mem_rvalid = 1'b0;
    tick(); tick();
    #1;
    total++; if (proto_err !== 1'b1) $display("FAIL stray_sticky: got %b want 1", proto_err); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total++; if (proto_err !== 1'b0) $display("FAIL stray_clear: got %b want 0", proto_err); else pass_cnt++;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    if_req = 1'b1; if_addr = 32'h500;
    tick();
    if_req = 1'b0; mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    #1;
    total++; if (busy !== 1'b1) $display("FAIL mid_busy_wait: got %b want 1", busy); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || mem_req !== 1'b0 || mem_addr !== 32'h0)
      $display("FAIL mid_reset: got busy=%b req=%b addr=%h want 0/0/0", busy, mem_req, mem_addr);
    else pass_cnt++;
    tick();
    rst_n = 1'b1;
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h99;
    #1;
    total++; if (if_rvalid !== 1'b0) $display("FAIL mid_late_rvalid: got %b want 0", if_rvalid); else pass_cnt++;
    tick();
    mem_rvalid = 1'b0;
    #1;
    total++; if (proto_err !== 1'b1) $display("FAIL mid_proto_err: got %b want 1", proto_err); else pass_cnt++;
    tick();
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int seen;
    seen = -1;
    if_req = 1'b1; if_addr = 32'h600;
    tick();
    if_req = 1'b0;
    for (int c = 0; c < 20 && seen < 0; c++) begin
      #1;
      if (if_rvalid === 1'b1) begin
        seen = c;
        total++; if (if_err !== 1'b1 || if_rdata !== 32'h0) $display("FAIL tmo_rsp: got err=%b rdata=%h want 1/0", if_err, if_rdata); else pass_cnt++;
      end
      tick();
    end
    total++; if (seen !== 8) $display("FAIL tmo_cycles: got %0d want 8", seen); else pass_cnt++;
    #1;
    total++; if (busy !== 1'b0 || mem_req !== 1'b0) $display("FAIL tmo_idle: got busy=%b req=%b want 0/0", busy, mem_req); else pass_cnt++;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_starvation();
    test_backpressure();
    test_stray();
    test_reset_mid();
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/riscv_mem_arbiter.md
Name: riscv_mem_arbiter

Overview:
- Shares one memory port between the RV32I core's instruction-fetch requester and data load/store requester.
- Allows one outstanding transaction at a time, using a three-state FSM.
- Priority is data over fetch, with a streak limit so fetch cannot be starved.
- Sits between the core's instr_addr/read_addr/write_addr side and the single-ported memory or bus.

Parameters:
- XLEN, 32: address and data width.
- MAX_STREAK, 4: consecutive data grants allowed while if_req is pending before fetch is forced to win.
- TIMEOUT, 255: cycles allowed in REQ+WAIT before an error completion; used only with MEM_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  XLEN  fetch address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  fetch response valid, 1-cycle pulse.
- if_rdata  out  XLEN  fetch read data.
- if_err  out  1  fetch response error, qualified by if_rvalid.
- d_req  in  1  data request; held until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  XLEN  data address.
- d_wdata  in  XLEN  store data.
- d_be  in  XLEN/8  byte enables.
- d_gnt  out  1  data request accepted.
- d_rvalid  out  1  data response valid, 1-cycle pulse; also pulses for stores.
- d_rdata  out  XLEN  load data.
- d_err  out  1  data response error.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  memory write enable.
- mem_addr  out  XLEN  memory address.
- mem_wdata  out  XLEN  memory write data.
- mem_be  out  XLEN/8  memory byte enables.
- mem_gnt  in  1  memory accepted the request.
- mem_rvalid  in  1  memory response valid.
- mem_rdata  in  XLEN  memory read data.
- mem_err  in  1  memory error, qualified by mem_rvalid.
- busy  out  1  FSM not in IDLE.
- proto_err  out  1  sticky: mem_rvalid seen outside WAIT.

Behaviour:
- Reset (rst_n low, async):
  - FSM goes to IDLE; owner and streak are cleared.
  - mem_req, mem_we, mem_addr, mem_wdata, mem_be, busy and proto_err are 0.
  - All requester outputs are 0.
  - Any in-flight transaction is dropped with no response.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - Arbitration is combinational: winner = data if d_req and not (if_req and streak==MAX_STREAK); otherwise fetch if if_req.
  - Only the winner's gnt is driven high, same cycle; at most one gnt is high per cycle.
  - On grant: latch the winner's addr/we/wdata/be into the mem_* registers, set owner, go to REQ.
  - Fetch transactions drive mem_we=0 and mem_be=all ones.
- Streak counter:
  - Incremented (saturating at MAX_STREAK) on each data grant while if_req=1.
  - Cleared on a fetch grant, or when a data grant occurs with if_req=0.
- REQ:
  - mem_req=1 and mem_* are held stable until mem_gnt=1, then go to WAIT.
  - mem_req drops in the cycle after mem_gnt.
- WAIT:
  - On mem_rvalid: pulse owner rvalid for that same cycle, with rdata=mem_rdata and err=mem_err, then go to IDLE.
  - The non-owner's rvalid stays 0.
- Latency:
  - Minimum is gnt at cycle 0, mem_req at cycle 1, mem_gnt at cycle 1, mem_rvalid at cycle 2, owner rvalid at cycle 2.
  - The next grant is possible at cycle 3.
- mem_rvalid in IDLE or REQ: ignored, sets proto_err=1, no requester response.
- mem_rvalid and mem_gnt in the same REQ cycle: the gnt is taken, the rvalid is treated as a protocol error.
- Requester outputs:
  - rdata/err are held at their last value when rvalid=0.
  - rdata is don't-care for stores; drive mem_rdata anyway.
- Width rules: addresses pass through unmodified; no alignment checking.

Optional Feature:
- Macro MEM_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to REQ and increments each cycle in REQ or WAIT.
  - When it reaches TIMEOUT, the owner receives rvalid=1, err=1, rdata=0, the FSM goes to IDLE, and mem_req drops.
  - A later stray mem_rvalid sets proto_err.
- Undefined: no counter; the FSM waits indefinitely.

Test Plan:
- Single fetch: if_req with if_addr=0x100, mem_gnt immediate, mem_rvalid at cycle 2 with rdata=0xDEADBEEF -> if_gnt at cycle 0, mem_addr=0x100, mem_we=0, if_rvalid at cycle 2 with if_rdata=0xDEADBEEF, if_err=0.
- Simultaneous requests: if_req=d_req=1 with d_we=1, d_addr=0x200, d_wdata=0x55, d_be=0xF -> d_gnt first, mem_we=1, mem_wdata=0x55; the fetch is granted in the IDLE after d_rvalid.
- Starvation: d_req and if_req held high continuously, MAX_STREAK=4 -> grant order D,D,D,D,F,D...
- Memory backpressure: mem_gnt held 0 for 5 cycles -> mem_req=1 and mem_addr/mem_wdata stable throughout; busy=1.
- Stray response: mem_rvalid=1 while in IDLE -> no rvalid on either requester; proto_err=1 until rst_n is asserted.
- Reset mid-operation: rst_n=0 while in WAIT -> mem_req=0 and busy=0 immediately; after release, a late mem_rvalid sets proto_err. With MEM_ARB_TIMEOUT_EN and TIMEOUT=8, no mem_gnt -> owner rvalid with err=1 eight cycles after entering REQ.
